syn_i2s_slave_xcvr: RTL

- I2S/DSP-mode-A slave transceiver for use when the WM8731 is the audio clock master and drives BCLK and LRC.
- Oversamples the codec BCLK/LRC in the clk_ir domain and shifts DAC PCM out, MSB first.
- Captures ADC PCM into the audio cache path.
- Counterpart of the existing FPGA-master WM8731 driver; sits between the acortex audio cache and the codec pins.

---
 rtl/syn_i2s_slave_xcvr.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/syn_i2s_slave_xcvr.sv
// I2S / DSP-mode-A slave transceiver for a WM8731 acting as audio clock master.
// The codec owns BCLK and LRC. Both are oversampled in the clk_ir domain.
// DAC PCM is shifted out MSB first. ADC PCM is captured into the egress pair.
// The bit index is log2(P_PCM_W) wide, so P_PCM_W must be at least 32 to hold a
// 32 bits/sample channel.
module syn_i2s_slave_xcvr #(
  parameter int P_SYNC_STAGES = 2,
  parameter int P_PCM_W       = 32
) (
  input  logic               clk_ir,
  input  logic               rst_sync,
  input  logic               dac_en,
  input  logic               adc_en,
  input  logic               bps,
  input  logic               codec_bclk,
  input  logic               codec_lrc,
  input  logic               codec_adc_dat,
  output logic               codec_dac_dat,
  input  logic               ingr_pcm_valid,
  input  logic [P_PCM_W-1:0] ingr_pcm_lchnnl,
  input  logic [P_PCM_W-1:0] ingr_pcm_rchnnl,
  output logic               ingr_ack,
  output logic               egr_pcm_valid,
  output logic [P_PCM_W-1:0] egr_pcm_lchnnl,
  output logic [P_PCM_W-1:0] egr_pcm_rchnnl,
  output logic               underrun,
  output logic               frame_err
);

  localparam int LP_CW = $clog2(P_PCM_W);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_FS, S_LCHNL, S_RCHNL} state_t;

  state_t                   r_state, w_state_nxt;
  logic [P_SYNC_STAGES-1:0] r_bclk_sync, r_lrc_sync, r_adc_sync;
  logic                     r_bclk_prev, r_lrc_smp;
  logic                     w_bclk_s, w_lrc_s, w_adc_s;
  logic                     w_bclk_rise, w_bclk_fall, w_fs;
  logic                     w_in_frame, w_last_bit, w_start, w_frm_done;
  logic [LP_CW-1:0]         r_bit_cnt, w_n_m1, w_tx_idx;
  logic                     r_bps, r_adc_en_f, r_dac_dat, r_egr_valid;
  logic [P_PCM_W-1:0]       r_tx_l, r_tx_r, r_rx_l, r_rx_r, w_rx_r_shift;
  logic [P_PCM_W-1:0]       r_egr_l, r_egr_r;

  // 16 bits/sample results are sign-extended to the full port width.
  function automatic logic [P_PCM_W-1:0] f_fmt(input logic [P_PCM_W-1:0] v, input logic wide);
    return wide ? v : {{(P_PCM_W-16){v[15]}}, v[15:0]};
  endfunction

  assign w_bclk_s     = r_bclk_sync[P_SYNC_STAGES-1];
  assign w_lrc_s      = r_lrc_sync[P_SYNC_STAGES-1];
  assign w_adc_s      = r_adc_sync[P_SYNC_STAGES-1];
  assign w_bclk_rise  = w_bclk_s & ~r_bclk_prev;
  assign w_bclk_fall  = ~w_bclk_s & r_bclk_prev;
  // The LRC value sampled on this rise is the live synchronised value. The previous one is r_lrc_smp.
  assign w_fs         = w_bclk_rise & w_lrc_s & ~r_lrc_smp;
  assign w_in_frame   = (r_state == S_LCHNL) || (r_state == S_RCHNL);
  assign w_n_m1       = r_bps ? LP_CW'(31) : LP_CW'(15);
  assign w_last_bit   = (r_bit_cnt == w_n_m1);
  assign w_tx_idx     = w_n_m1 - r_bit_cnt;
  assign w_rx_r_shift = {r_rx_r[P_PCM_W-2:0], w_adc_s};

  assign codec_dac_dat  = r_dac_dat & dac_en & w_in_frame;
  assign egr_pcm_valid  = r_egr_valid;
  assign egr_pcm_lchnnl = r_egr_l;
  assign egr_pcm_rchnnl = r_egr_r;

  // Synchronise the codec pins and keep the BCLK and LRC history used for edge detection.
  always_ff @(posedge clk_ir or posedge rst_sync) begin
    if (rst_sync) begin
      r_bclk_sync <= '0;
      r_lrc_sync  <= '0;
      r_adc_sync  <= '0;
      r_bclk_prev <= 1'b0;
      r_lrc_smp   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage see the previous stage's old value, forming a real shift chain.
      r_bclk_sync <= {r_bclk_sync[P_SYNC_STAGES-2:0], codec_bclk};
      r_lrc_sync  <= {r_lrc_sync[P_SYNC_STAGES-2:0], codec_lrc};
      r_adc_sync  <= {r_adc_sync[P_SYNC_STAGES-2:0], codec_adc_dat};
      r_bclk_prev <= w_bclk_s;
      if (w_bclk_rise) r_lrc_smp <= w_lrc_s;
    end
  end

  // State register.
  always_ff @(posedge clk_ir or posedge rst_sync) begin
    if (rst_sync) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic plus the frame-start strobes (ack, underrun, frame error).
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a value held and no latch is inferred.
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_frm_done  = 1'b0;
    frame_err   = 1'b0;
    ingr_ack    = 1'b0;
    underrun    = 1'b0;
    case (r_state)
      S_IDLE:    if (dac_en || adc_en) w_state_nxt = S_WAIT_FS;
      S_WAIT_FS: begin
        if (!(dac_en || adc_en)) w_state_nxt = S_IDLE;
        else if (w_fs) begin
          w_start     = 1'b1;
          w_state_nxt = S_LCHNL;
        end
      end
      S_LCHNL, S_RCHNL: begin
        if (w_fs) begin
          // An early frame start drops the partial frame and restarts it cleanly.
          frame_err   = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = S_LCHNL;
        end else if (w_bclk_rise && w_last_bit) begin
          w_state_nxt = (r_state == S_LCHNL) ? S_RCHNL : S_WAIT_FS;
          w_frm_done  = (r_state == S_RCHNL);
        end
      end
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_start) begin
      ingr_ack = dac_en & ingr_pcm_valid;
      underrun = dac_en & ~ingr_pcm_valid;
    end
  end

  // Per-frame datapath: bit counter, transmit and receive registers, DAC bit and egress pair.
  always_ff @(posedge clk_ir or posedge rst_sync) begin
    if (rst_sync) begin
      r_bit_cnt   <= '0;
      r_bps       <= 1'b0;
      r_adc_en_f  <= 1'b0;
      r_tx_l      <= '0;
      r_tx_r      <= '0;
      r_rx_l      <= '0;
      r_rx_r      <= '0;
      r_dac_dat   <= 1'b0;
      r_egr_valid <= 1'b0;
      r_egr_l     <= '0;
      r_egr_r     <= '0;
    end else begin
      r_egr_valid <= 1'b0;
      if (w_start) begin
        r_bit_cnt  <= '0;
        r_bps      <= bps;
        r_adc_en_f <= adc_en;
        r_tx_l     <= (dac_en && ingr_pcm_valid) ? ingr_pcm_lchnnl : '0;
        r_tx_r     <= (dac_en && ingr_pcm_valid) ? ingr_pcm_rchnnl : '0;
        r_rx_l     <= '0;
        r_rx_r     <= '0;
        r_dac_dat  <= 1'b0;
      end else begin
        if (w_bclk_rise && w_in_frame) begin
          r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
          if (r_state == S_LCHNL) r_rx_l <= {r_rx_l[P_PCM_W-2:0], w_adc_s};
          else                    r_rx_r <= w_rx_r_shift;
        end
        if (w_frm_done) begin
          r_dac_dat <= 1'b0;
          if (r_adc_en_f) begin
            r_egr_valid <= 1'b1;
            r_egr_l     <= f_fmt(r_rx_l, r_bps);
            r_egr_r     <= f_fmt(w_rx_r_shift, r_bps);
          end
        end else if (w_bclk_fall) begin
          // Mode A: the bit is driven on the fall so the codec samples it on the next rise.
          case (r_state)
            S_LCHNL: r_dac_dat <= r_tx_l[w_tx_idx];
            S_RCHNL: r_dac_dat <= r_tx_r[w_tx_idx];
            default: r_dac_dat <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule
